// File: rtl/pe_accel_pkg.sv
// Shared constants for the PE-array accelerator blocks.
// Holds the sequencer state encodings, the job column-count width and helpers
// that derive slice widths from the array geometry parameters.
package pe_accel_pkg;

    typedef logic [2:0] seq_state_t;

    // Sequencer states, kept as plain constants so older blocks can compare raw bits.
    localparam seq_state_t StIdle  = 3'd0;
    localparam seq_state_t StLoad  = 3'd1;
    localparam seq_state_t StFire  = 3'd2;
    localparam seq_state_t StWait  = 3'd3;
    localparam seq_state_t StDrain = 3'd4;

    localparam int unsigned ColsWidth = 16;

    // Bits in one operand row slice (all PEs of one array row).
    function automatic int unsigned row_bits(input int unsigned pes, input int unsigned macs,
                                             input int unsigned width);
        return pes * macs * width;
    endfunction

    // Bits in one result row (double-width accumulators, one per MAC).
    function automatic int unsigned res_row_bits(input int unsigned macs,
                                                 input int unsigned width);
        return macs * 2 * width;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_result_drain.sv
// Result capture and row serialiser for the PE-array sequencer.
// capture loads the whole result bus in one cycle and rewinds the row pointer;
// while drain_en is high one row per res_valid/res_ready handshake is presented,
// lowest row first, and drain_done pulses on the handshake of the final row.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   capture           - load results_flat and restart at row 0
//   results_flat      - full result bus from the array
//   drain_en          - sequencer is in its drain phase
//   res_valid/ready   - row handshake
//   res_data/res_last - current row and final-row marker
//   drain_done        - final row accepted
module pe_result_drain
    import pe_accel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_MACS   = 4,
    parameter int unsigned NUM_ROWS   = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     capture,
    input  logic [NUM_ROWS*NUM_MACS*2*DATA_WIDTH-1:0] results_flat,
    input  logic                                     drain_en,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [NUM_MACS*2*DATA_WIDTH-1:0]          res_data,
    output logic                                     res_last,
    output logic                                     drain_done
);

    localparam int unsigned ResRowBits = res_row_bits(NUM_MACS, DATA_WIDTH);
    localparam int unsigned RowW       = cnt_width(NUM_ROWS);

    logic [NUM_ROWS*ResRowBits-1:0] cap_d, cap_q;
    logic [RowW-1:0]                row_d, row_q;
    logic                           row_is_last;

    assign row_is_last = (row_q == RowW'(NUM_ROWS - 1));

    always_comb begin
        cap_d = cap_q;
        row_d = row_q;
        if (capture) begin
            cap_d = results_flat;
            row_d = '0;
        end else if (drain_en && res_ready) begin
            // Wrap to 0 so the pointer is ready for the next job without a capture.
            row_d = row_is_last ? '0 : row_q + RowW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
            row_q <= '0;
        end else begin
            cap_q <= cap_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        res_valid  = drain_en;
        res_last   = drain_en & row_is_last;
        res_data   = '0;
        if (drain_en) begin
            res_data = cap_q[int'(row_q)*ResRowBits +: ResRowBits];
        end
        drain_done = drain_en & res_ready & row_is_last;
    end

endmodule

// File: rtl/pe_array_sequencer.sv
// Job sequencer for a NUM_ROWS x NUM_PEs PE array.
// Accepts a job descriptor, gathers NUM_ROWS operand row beats into packed flat
// buses, pulses arr_start, waits (bounded by TIMEOUT) for arr_done, then streams
// the captured results out one row per handshake.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   job_valid/job_ready, job_cols    - job descriptor handshake
//   in_valid/in_ready, in_*_row      - operand row beats
//   arr_start, arr_workload_cols,
//   arr_matrix_flat, arr_vector_flat - array launch interface
//   arr_done, arr_results_flat       - array completion and results
//   res_valid/res_ready, res_data,
//   res_last                         - result row stream
//   busy                             - not idle
//   err                              - rejected job (cols == 0) or array timeout
module pe_array_sequencer
    import pe_accel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_PEs    = 4,
    parameter int unsigned NUM_MACS   = 4,
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              job_valid,
    output logic                                              job_ready,
    input  logic [ColsWidth-1:0]                              job_cols,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [NUM_PEs*NUM_MACS*DATA_WIDTH-1:0]            in_matrix_row,
    input  logic [NUM_PEs*NUM_MACS*DATA_WIDTH-1:0]            in_vector_row,
    output logic                                              arr_start,
    output logic [ColsWidth-1:0]                              arr_workload_cols,
    output logic [NUM_ROWS*NUM_PEs*NUM_MACS*DATA_WIDTH-1:0]   arr_matrix_flat,
    output logic [NUM_ROWS*NUM_PEs*NUM_MACS*DATA_WIDTH-1:0]   arr_vector_flat,
    input  logic                                              arr_done,
    input  logic [NUM_ROWS*NUM_MACS*2*DATA_WIDTH-1:0]         arr_results_flat,
    output logic                                              res_valid,
    input  logic                                              res_ready,
    output logic [NUM_MACS*2*DATA_WIDTH-1:0]                  res_data,
    output logic                                              res_last,
    output logic                                              busy,
    output logic                                              err
);

    localparam int unsigned RowBits  = row_bits(NUM_PEs, NUM_MACS, DATA_WIDTH);
    localparam int unsigned FlatBits = NUM_ROWS * RowBits;
    localparam int unsigned RowW     = cnt_width(NUM_ROWS);
    localparam int unsigned TmoW     = cnt_width(TIMEOUT);

    seq_state_t           state_d, state_q;
    logic [RowW-1:0]      row_d, row_q;
    logic [TmoW-1:0]      tmo_d, tmo_q;
    logic [ColsWidth-1:0] cols_d, cols_q;
    logic [FlatBits-1:0]  mat_d, mat_q;
    logic [FlatBits-1:0]  vec_d, vec_q;

    logic job_acc, job_rej, timeout_hit, capture, drain_en, drain_done;

    // Idle outputs are masked during reset so every output reads 0 while rst is high.
    assign job_ready   = (state_q == StIdle) & ~rst;
    assign job_acc     = job_ready & job_valid & (job_cols != '0);
    assign job_rej     = job_ready & job_valid & (job_cols == '0);
    assign timeout_hit = (state_q == StWait) & ~arr_done & (tmo_q == TmoW'(TIMEOUT - 1));

    assign in_ready          = (state_q == StLoad);
    assign arr_start         = (state_q == StFire);
    assign busy              = (state_q != StIdle);
    assign err               = job_rej | timeout_hit;
    assign drain_en          = (state_q == StDrain);
    assign arr_workload_cols = cols_q;
    assign arr_matrix_flat   = mat_q;
    assign arr_vector_flat   = vec_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tmo_d   = tmo_q;
        cols_d  = cols_q;
        mat_d   = mat_q;
        vec_d   = vec_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (job_acc) begin
                    cols_d  = job_cols;
                    row_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    mat_d[int'(row_q)*RowBits +: RowBits] = in_matrix_row;
                    vec_d[int'(row_q)*RowBits +: RowBits] = in_vector_row;
                    if (row_q == RowW'(NUM_ROWS - 1)) begin
                        state_d = StFire;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            StFire: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done arriving on the final allowed cycle still wins over the timeout.
                if (arr_done) begin
                    capture = 1'b1;
                    state_d = StDrain;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            tmo_q   <= '0;
            cols_q  <= '0;
            mat_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tmo_q   <= tmo_d;
            cols_q  <= cols_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
        end
    end

    pe_result_drain #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_MACS   (NUM_MACS),
        .NUM_ROWS   (NUM_ROWS)
    ) u_drain (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .results_flat (arr_results_flat),
        .drain_en     (drain_en),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_last     (res_last),
        .drain_done   (drain_done)
    );

endmodule

// File: tb/tb_pe_array_sequencer.sv
module tb_pe_array_sequencer;

    localparam int DW       = 16;
    localparam int PES      = 4;
    localparam int MACS     = 4;
    localparam int ROWS     = 4;
    localparam int TMO      = 16;
    localparam int RowBits  = PES * MACS * DW;
    localparam int FlatBits = ROWS * RowBits;
    localparam int ResRow   = MACS * 2 * DW;
    localparam int ResBits  = ROWS * ResRow;
    localparam int Budget   = 64;

    typedef logic [1023:0] wide_t;

    typedef struct {
        logic [15:0] cols;
        int          delay;       // cycles after arr_start at which arr_done is pulsed
        bit          withhold;    // never pulse arr_done
        int          stall_mode;  // 0 always ready, 1 toggle 0/1, 2 random
        bit          spurious;    // pulse arr_done during LOAD
        bit          exp_timeout;
        int          exp_beats;
    } job_vec_t;

    typedef struct {
        logic        jv;
        logic [15:0] cols;
        logic        exp_ready;
        logic        exp_err;
    } probe_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                job_valid;
    logic                job_ready;
    logic [15:0]         job_cols;
    logic                in_valid;
    logic                in_ready;
    logic [RowBits-1:0]  in_matrix_row;
    logic [RowBits-1:0]  in_vector_row;
    logic                arr_start;
    logic [15:0]         arr_workload_cols;
    logic [FlatBits-1:0] arr_matrix_flat;
    logic [FlatBits-1:0] arr_vector_flat;
    logic                arr_done;
    logic [ResBits-1:0]  arr_results_flat;
    logic                res_valid;
    logic                res_ready;
    logic [ResRow-1:0]   res_data;
    logic                res_last;
    logic                busy;
    logic                err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_array_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_PEs    (PES),
        .NUM_MACS   (MACS),
        .NUM_ROWS   (ROWS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_cols          (job_cols),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_matrix_row     (in_matrix_row),
        .in_vector_row     (in_vector_row),
        .arr_start         (arr_start),
        .arr_workload_cols (arr_workload_cols),
        .arr_matrix_flat   (arr_matrix_flat),
        .arr_vector_flat   (arr_vector_flat),
        .arr_done          (arr_done),
        .arr_results_flat  (arr_results_flat),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_last          (res_last),
        .busy              (busy),
        .err               (err)
    );

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h (low bits) required %0h (low bits)", name, act[191:0],
                     exp[191:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wide_t rand_wide();
        wide_t v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference behaviour of one job, expressed as observable milestones:
    // arr_start NUM_ROWS+1 cycles after acceptance, flat buses equal to the
    // concatenated row beats, arr_done consumed or a timeout after TIMEOUT cycles,
    // then the captured result rows in order.
    task automatic run_job(input job_vec_t jv);
        logic [RowBits-1:0]  mat [ROWS];
        logic [RowBits-1:0]  vec [ROWS];
        logic [FlatBits-1:0] exp_mat;
        logic [FlatBits-1:0] exp_vec;
        logic [ResBits-1:0]  results;
        logic [ResRow-1:0]   held_data;
        wide_t               tmp;
        int                  cyc, k, n, m, beats;
        bit                  seen_start, stable, got_err, got_done, held, held_last;

        for (int r = 0; r < ROWS; r++) begin
            tmp = rand_wide();
            mat[r] = tmp[RowBits-1:0];
            tmp = rand_wide();
            vec[r] = tmp[RowBits-1:0];
            exp_mat[r*RowBits +: RowBits] = mat[r];
            exp_vec[r*RowBits +: RowBits] = vec[r];
        end
        tmp = rand_wide();
        results = tmp[ResBits-1:0];

        job_valid = 1'b1;
        job_cols  = jv.cols;
        #1;
        chk("job_ready_idle", wide_t'(job_ready), wide_t'(1'b1));
        chk("no_err_on_accept", wide_t'(err), wide_t'(1'b0));
        tick();
        job_valid = 1'b0;

        cyc = 1;
        k = 0;
        seen_start = 0;
        while (!seen_start && cyc <= Budget) begin
            in_valid      = 1'b1;
            in_matrix_row = (k < ROWS) ? mat[k] : '1;
            in_vector_row = (k < ROWS) ? vec[k] : '1;
            arr_done      = jv.spurious && (k == 1);
            #1;
            if (arr_start) begin
                seen_start = 1;
            end else begin
                if (in_ready) k++;
                tick();
                cyc++;
            end
        end
        chk("start_latency", wide_t'(cyc), wide_t'(ROWS + 1));
        chk("beats_loaded", wide_t'(k), wide_t'(ROWS));
        chk("busy_fire", wide_t'(busy), wide_t'(1'b1));
        chk("matrix_flat", wide_t'(arr_matrix_flat), wide_t'(exp_mat));
        chk("vector_flat", wide_t'(arr_vector_flat), wide_t'(exp_vec));
        chk("workload_cols", wide_t'(arr_workload_cols), wide_t'(jv.cols));
        in_valid = 1'b0;
        arr_done = 1'b0;

        tick();
        n = 1;
        #1;
        chk("start_one_cycle", wide_t'(arr_start), wide_t'(1'b0));
        stable   = 1;
        got_err  = 0;
        got_done = 0;
        while (n <= Budget) begin
            if (!jv.withhold && n == jv.delay) begin
                arr_done         = 1'b1;
                arr_results_flat = results;
            end else begin
                arr_done         = 1'b0;
                tmp              = rand_wide();
                arr_results_flat = tmp[ResBits-1:0];
            end
            #1;
            if (arr_matrix_flat !== exp_mat || arr_vector_flat !== exp_vec ||
                arr_workload_cols !== jv.cols) stable = 0;
            if (err) begin
                got_err = 1;
                break;
            end
            if (arr_done) begin
                got_done = 1;
                break;
            end
            tick();
            n++;
        end
        chk("operands_stable", wide_t'(stable), wide_t'(1'b1));
        chk("timeout_err", wide_t'(got_err), wide_t'(jv.exp_timeout));

        if (got_err) begin
            chk("timeout_cycle", wide_t'(n), wide_t'(TMO));
            tick();
            arr_done = 1'b0;
            #1;
            chk("idle_after_timeout", wide_t'(busy), wide_t'(1'b0));
            chk("ready_after_timeout", wide_t'(job_ready), wide_t'(1'b1));
            chk("no_res_after_timeout", wide_t'(res_valid), wide_t'(1'b0));
            return;
        end
        if (!got_done) return;

        tick();
        arr_done         = 1'b0;
        arr_results_flat = ~results;
        beats = 0;
        m     = 0;
        held  = 0;
        held_last = 0;
        held_data = '0;
        while (beats < ROWS && m <= Budget) begin
            case (jv.stall_mode)
                1:       res_ready = (m % 2) == 1;
                2:       res_ready = ($urandom % 2) == 1;
                default: res_ready = 1'b1;
            endcase
            #1;
            chk("res_valid_drain", wide_t'(res_valid), wide_t'(1'b1));
            if (held) begin
                chk("stall_data_hold", wide_t'(res_data), wide_t'(held_data));
                chk("stall_last_hold", wide_t'(res_last), wide_t'(held_last));
            end
            if (res_valid && res_ready) begin
                chk("res_row", wide_t'(res_data), wide_t'(results[beats*ResRow +: ResRow]));
                chk("res_last", wide_t'(res_last), wide_t'(beats == ROWS - 1));
                beats++;
                held = 0;
            end else if (res_valid) begin
                held      = 1;
                held_data = res_data;
                held_last = res_last;
            end
            tick();
            m++;
        end
        res_ready = 1'b0;
        #1;
        chk("beat_count", wide_t'(beats), wide_t'(jv.exp_beats));
        chk("no_extra_beat", wide_t'(res_valid), wide_t'(1'b0));
        chk("b2b_job_ready", wide_t'(job_ready), wide_t'(1'b1));
    endtask

    job_vec_t jobs [5];
    probe_t   probes [4];
    job_vec_t rj;

    initial begin
        jobs[0] = '{cols: 16'd20,   delay: 6, withhold: 0, stall_mode: 0, spurious: 0,
                    exp_timeout: 0, exp_beats: ROWS};
        jobs[1] = '{cols: 16'hFFFF, delay: 1, withhold: 0, stall_mode: 1, spurious: 0,
                    exp_timeout: 0, exp_beats: ROWS};
        jobs[2] = '{cols: 16'd3,    delay: 0, withhold: 1, stall_mode: 0, spurious: 0,
                    exp_timeout: 1, exp_beats: 0};
        jobs[3] = '{cols: 16'd5,    delay: 4, withhold: 0, stall_mode: 0, spurious: 1,
                    exp_timeout: 0, exp_beats: ROWS};
        jobs[4] = '{cols: 16'd1,    delay: 1, withhold: 0, stall_mode: 2, spurious: 0,
                    exp_timeout: 0, exp_beats: ROWS};
        probes[0] = '{jv: 1'b0, cols: 16'd0, exp_ready: 1'b1, exp_err: 1'b0};
        probes[1] = '{jv: 1'b1, cols: 16'd0, exp_ready: 1'b1, exp_err: 1'b1};
        probes[2] = '{jv: 1'b0, cols: 16'd7, exp_ready: 1'b1, exp_err: 1'b0};
        probes[3] = '{jv: 1'b1, cols: 16'd0, exp_ready: 1'b1, exp_err: 1'b1};

        rst              = 1'b1;
        job_valid        = 1'b1;
        job_cols         = '0;
        in_valid         = 1'b0;
        in_matrix_row    = '0;
        in_vector_row    = '0;
        arr_done         = 1'b0;
        arr_results_flat = '0;
        res_ready        = 1'b0;
        #2;
        chk("rst_job_ready", wide_t'(job_ready), wide_t'(1'b0));
        chk("rst_err", wide_t'(err), wide_t'(1'b0));
        chk("rst_busy", wide_t'(busy), wide_t'(1'b0));
        chk("rst_outs", wide_t'({in_ready, arr_start, res_valid, res_last}), wide_t'(4'b0));
        chk("rst_flat", wide_t'(arr_matrix_flat | arr_vector_flat), wide_t'(0));
        chk("rst_res_data", wide_t'(res_data), wide_t'(0));
        job_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", wide_t'(job_ready), wide_t'(1'b1));

        for (int i = 0; i < 4; i++) begin
            job_valid = probes[i].jv;
            job_cols  = probes[i].cols;
            #1;
            chk("probe_ready", wide_t'(job_ready), wide_t'(probes[i].exp_ready));
            chk("probe_err", wide_t'(err), wide_t'(probes[i].exp_err));
            chk("probe_no_start", wide_t'(arr_start), wide_t'(1'b0));
            tick();
            job_valid = 1'b0;
            #1;
            chk("probe_err_one_cycle", wide_t'(err), wide_t'(1'b0));
            chk("probe_stays_idle", wide_t'(busy), wide_t'(1'b0));
        end

        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Reset after the third load beat abandons the job silently.
        job_valid = 1'b1;
        job_cols  = 16'd9;
        #1;
        tick();
        job_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid      = 1'b1;
            in_matrix_row = {8{32'hA5A5_0000 + 32'(k)}};
            in_vector_row = {8{32'h5A5A_0000 + 32'(k)}};
            #1;
            chk("mid_load_ready", wide_t'(in_ready), wide_t'(1'b1));
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_outs",
            wide_t'({job_ready, in_ready, arr_start, res_valid, res_last, busy, err}),
            wide_t'(7'b0));
        chk("midrst_flat", wide_t'(arr_matrix_flat | arr_vector_flat), wide_t'(0));
        chk("midrst_cols", wide_t'(arr_workload_cols), wide_t'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", wide_t'(job_ready), wide_t'(1'b1));
        chk("midrst_release_start", wide_t'(arr_start), wide_t'(1'b0));
        run_job(jobs[0]);

        for (int i = 0; i < 20; i++) begin
            rj.cols        = 16'($urandom_range(65535, 1));
            rj.delay       = int'($urandom_range(10, 1));
            rj.withhold    = ($urandom % 8) == 0;
            rj.stall_mode  = int'($urandom_range(2, 0));
            rj.spurious    = ($urandom % 2) == 1;
            rj.exp_timeout = rj.withhold;
            rj.exp_beats   = rj.withhold ? 0 : ROWS;
            run_job(rj);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
